uart_tx_sched: RTL and testbench

- UART transmit controller built around a fractional phase-accumulator baud tick (acc[N:0] <= acc[N-1:0] + INC; tick = acc[N]).
- Buffers bytes in a small FIFO and gates the accumulator so it only runs while a frame is on the line.
- Sequences start, data, optional parity and stop bits from the ticks.
- Sits between CPU-side byte writers and the TXD pin.

---
 rtl/uart_tx_sched.sv | 217 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop sequencer paced by a
// gated fractional phase accumulator that only runs while a frame is on the line.
module uart_tx_sched #(
  parameter int unsigned INC        = 151,
  parameter int unsigned N          = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  CLK50MHZ,
  input  logic                  RST,
  input  logic [7:0]            data_in,
  input  logic                  wr_en,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_odd,
  input  logic                  cfg_two_stop,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic                  txd
);

  localparam int unsigned         Depth    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthLvl = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [N:0]          IncVal   = (N + 1)'(INC);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  push;
  logic                  pop;
  logic                  have_data;
  logic [7:0]            rd_data;

  // Frame sequencer state
  state_e     state_q;
  state_e     state_d;
  logic [2:0] bit_q;
  logic [2:0] bit_d;
  logic [7:0] data_q;
  logic [7:0] data_d;
  logic       par_en_q;
  logic       par_en_d;
  logic       par_odd_q;
  logic       par_odd_d;
  logic       two_stop_q;
  logic       two_stop_d;
  logic [N:0] acc_q;
  logic [N:0] acc_d;
  logic       txd_q;
  logic       txd_d;
  logic       tick;

  assign full      = (count_q == DepthLvl);
  assign level     = count_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != StIdle);
  assign txd       = txd_q;
  assign tick      = acc_q[N];
  assign have_data = (count_q != '0);
  assign rd_data   = mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a write while full is still accepted then.
  assign push  = wr_en && (!full || pop);
  assign ovf_d = wr_en && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (push) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + DEPTH_LOG2'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; frame registers are loaded only when a byte is popped.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (have_data) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? StParity : StStop1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop1;
        end
      end
      StStop1, StStop2: begin
        if (tick) begin
          if ((state_q == StStop1) && two_stop_q) begin
            state_d = StStop2;
          end else if (have_data) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      data_d     = rd_data;
      par_en_d   = cfg_parity_en;
      par_odd_d  = cfg_parity_odd;
      two_stop_d = cfg_two_stop;
    end
  end

  // First accumulation happens on the IDLE->START edge; phase carries across frames.
  always_comb begin
    acc_d = acc_q;
    if (state_q == StIdle) begin
      if (state_d == StStart) begin
        acc_d = IncVal;
      end
    end else begin
      acc_d = {1'b0, acc_q[N-1:0]} + IncVal;
    end
  end

  // Line level is decoded from the upcoming state so txd is a clean register output.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = data_d[bit_d];
      StParity: txd_d = (^data_d) ^ par_odd_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      bit_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      acc_q      <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      acc_q      <= acc_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a 4-clock bit period (INC=64, N=8).
module tb_uart_tx_sched;

  localparam int unsigned Inc       = 64;
  localparam int unsigned NBits     = 8;
  localparam int unsigned DepthLog2 = 2;
  localparam int          BitClks   = 4;

  logic                 CLK50MHZ = 1'b0;
  logic                 RST = 1'b0;
  logic [7:0]           data_in = '0;
  logic                 wr_en = 1'b0;
  logic                 cfg_parity_en = 1'b0;
  logic                 cfg_parity_odd = 1'b0;
  logic                 cfg_two_stop = 1'b0;
  logic                 full;
  logic [DepthLog2:0]   level;
  logic                 overflow;
  logic                 busy;
  logic                 txd;

  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];

  always #10 CLK50MHZ = ~CLK50MHZ;

  uart_tx_sched #(
    .INC        (Inc),
    .N          (NBits),
    .DEPTH_LOG2 (DepthLog2)
  ) dut (
    .CLK50MHZ       (CLK50MHZ),
    .RST            (RST),
    .data_in        (data_in),
    .wr_en          (wr_en),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .full           (full),
    .level          (level),
    .overflow       (overflow),
    .busy           (busy),
    .txd            (txd)
  );

  // Line bits of one frame in send order; unused tail positions are stop level.
  function automatic logic [11:0] frame_vec(input logic [7:0] b, input logic pen,
                                            input logic podd);
    logic [11:0] v;
    v      = '1;
    v[0]   = 1'b0;
    v[8:1] = b;
    if (pen) v[9] = (^b) ^ podd;
    return v;
  endfunction

  function automatic int frame_bits(input logic pen, input logic two);
    return 10 + int'(pen) + int'(two);
  endfunction

  task automatic push_frame(input logic [7:0] b, input logic pen, input logic podd,
                            input logic two);
    logic [11:0] v;
    v = frame_vec(b, pen, podd);
    for (int i = 0; i < frame_bits(pen, two); i++)
      for (int c = 0; c < BitClks; c++) exp_q.push_back(v[i]);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge CLK50MHZ);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || level !== 0 || full !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: txd=%b busy=%b level=%0d full=%b overflow=%b, required 1 0 0 0 0",
               txd, busy, level, full, overflow);
    end
    RST = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge CLK50MHZ);
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || level !== 0) begin
        failures++;
        $display("FAIL idle_cycle%0d: txd=%b busy=%b level=%0d, required 1 0 0", j, txd, busy, level);
      end
    end
  endtask

  task automatic test_single_byte();
    exp_q.delete();
    push_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge CLK50MHZ);
    data_in = 8'hA5; wr_en = 1'b1;
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
    @(negedge CLK50MHZ);
    wr_en = 1'b0;
    checks++;
    if (level !== 1 || busy !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL single_after_write: level=%0d busy=%b txd=%b, required 1 0 1", level, busy, txd);
    end
    for (int j = 1; j <= 40; j++) begin
      @(negedge CLK50MHZ);
      checks++;
      if (txd !== exp_q[j-1] || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_bit_clk%0d: txd=%b busy=%b, required %b 1", j, txd, busy, exp_q[j-1]);
      end
      if (j == 1) begin
        checks++;
        if (level !== 0) begin
          failures++;
          $display("FAIL single_pop_level: level=%0d, required 0", level);
        end
      end
      // Mid-frame config change must not affect the frame in flight.
      if (j == 20) begin
        cfg_parity_en = 1'b1; cfg_two_stop = 1'b1;
      end
    end
    @(negedge CLK50MHZ);
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      failures++;
      $display("FAIL single_end: busy=%b txd=%b, required 0 1", busy, txd);
    end
    cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
  endtask

  task automatic test_parity();
    int total;
    for (int k = 0; k < 2; k++) begin
      logic odd;
      odd = (k == 0);
      exp_q.delete();
      push_frame(8'h03, 1'b1, odd, odd);
      total = exp_q.size();
      @(negedge CLK50MHZ);
      data_in = 8'h03; wr_en = 1'b1;
      cfg_parity_en = 1'b1; cfg_parity_odd = odd; cfg_two_stop = odd;
      @(negedge CLK50MHZ);
      wr_en = 1'b0;
      for (int j = 1; j <= total + 1; j++) begin
        @(negedge CLK50MHZ);
        if (j <= total) begin
          checks++;
          if (txd !== exp_q[j-1] || busy !== 1'b1) begin
            failures++;
            $display("FAIL parity%0d_clk%0d: txd=%b busy=%b, required %b 1", k, j, txd, busy,
                     exp_q[j-1]);
          end
        end else begin
          checks++;
          if (busy !== 1'b0 || txd !== 1'b1) begin
            failures++;
            $display("FAIL parity%0d_len: busy=%b txd=%b at clk %0d, required 0 1", k, busy, txd, j);
          end
        end
        if (j == 37) begin
          checks++;
          if (txd !== odd) begin
            failures++;
            $display("FAIL parity%0d_bit: txd=%b, required %b", k, txd, odd);
          end
        end
      end
      checks++;
      if (total != (odd ? 48 : 44)) begin
        failures++;
        $display("FAIL parity%0d_model_len: got %0d", k, total);
      end
    end
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    int total;
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_frame(8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    push_frame(8'h16, 1'b0, 1'b0, 1'b0);
    total = exp_q.size();
    @(negedge CLK50MHZ);
    data_in = 8'h11; wr_en = 1'b1;
    for (int j = 0; j <= total + 1; j++) begin
      @(negedge CLK50MHZ);
      if (j == 0) begin
        checks++;
        if (busy !== 1'b0 || level !== 1) begin
          failures++;
          $display("FAIL b2b_first: busy=%b level=%0d, required 0 1", busy, level);
        end
      end else if (j <= total) begin
        checks++;
        if (txd !== exp_q[j-1] || busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_clk%0d: txd=%b busy=%b, required %b 1", j, txd, busy, exp_q[j-1]);
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || txd !== 1'b1 || level !== 0) begin
          failures++;
          $display("FAIL b2b_end: busy=%b txd=%b level=%0d, required 0 1 0", busy, txd, level);
        end
      end
      checks++;
      if (overflow !== (j == 5)) begin
        failures++;
        $display("FAIL b2b_overflow_clk%0d: overflow=%b, required %b", j, overflow, (j == 5));
      end
      if (j == 4 || j == 5 || j == 40 || j == 41) begin
        checks++;
        if (level !== 4 || full !== 1'b1) begin
          failures++;
          $display("FAIL b2b_full_clk%0d: level=%0d full=%b, required 4 1", j, level, full);
        end
      end
      wr_en = 1'b0;
      if (j <= 3) begin
        data_in = 8'(8'h11 + j + 1); wr_en = 1'b1;
      end else if (j == 4) begin
        data_in = 8'hEE; wr_en = 1'b1;
      end else if (j == 40) begin
        data_in = 8'h16; wr_en = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    int         n;
    int         total;
    logic       pen;
    logic       podd;
    logic       two;
    logic [7:0] b [5];
    for (int r = 0; r < 8; r++) begin
      n    = int'($urandom_range(5, 1));
      pen  = 1'($urandom);
      podd = 1'($urandom);
      two  = 1'($urandom);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        b[i] = 8'($urandom);
        push_frame(b[i], pen, podd, two);
      end
      total = exp_q.size();
      @(negedge CLK50MHZ);
      cfg_parity_en = pen; cfg_parity_odd = podd; cfg_two_stop = two;
      data_in = b[0]; wr_en = 1'b1;
      for (int j = 0; j <= total + 1; j++) begin
        @(negedge CLK50MHZ);
        if (j >= 1 && j <= total) begin
          checks++;
          if (txd !== exp_q[j-1] || busy !== 1'b1) begin
            failures++;
            $display("FAIL rand%0d_clk%0d: txd=%b busy=%b, required %b 1", r, j, txd, busy,
                     exp_q[j-1]);
          end
        end else if (j == total + 1) begin
          checks++;
          if (busy !== 1'b0 || txd !== 1'b1 || level !== 0) begin
            failures++;
            $display("FAIL rand%0d_end: busy=%b txd=%b level=%0d, required 0 1 0", r, busy, txd,
                     level);
          end
        end
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL rand%0d_overflow_clk%0d: overflow=%b, required 0", r, j, overflow);
        end
        wr_en = 1'b0;
        if (j + 1 < n) begin
          data_in = b[j+1]; wr_en = 1'b1;
        end
      end
      repeat ($urandom_range(3, 0)) @(negedge CLK50MHZ);
    end
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK50MHZ);
    data_in = 8'h00; wr_en = 1'b1;
    @(negedge CLK50MHZ);
    data_in = 8'hFF;
    @(negedge CLK50MHZ);
    wr_en = 1'b0;
    repeat (15) @(negedge CLK50MHZ);
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1 || level !== 1) begin
      failures++;
      $display("FAIL rstmid_before: txd=%b busy=%b level=%0d, required 0 1 1", txd, busy, level);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || level !== 0 || full !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: txd=%b busy=%b level=%0d full=%b, required 1 0 0 0",
               txd, busy, level, full);
    end
    repeat (2) @(negedge CLK50MHZ);
    RST = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(negedge CLK50MHZ);
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || level !== 0) begin
        failures++;
        $display("FAIL rstmid_after_clk%0d: txd=%b busy=%b level=%0d, required 1 0 0",
                 j, txd, busy, level);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
